// File: rtl/decode_ctrl.sv
// Decode front end: classifies the opcode into an immediate format and buffers up to two entries (main + skid).
// Latency 1 cycle in->out; in_ready is ~skid_valid (registered), so out_ready never reaches in_ready combinationally.

package decode_pkg;
  typedef enum logic [2:0] {
    I_TYPE = 3'd0,
    S_TYPE = 3'd1,
    B_TYPE = 3'd2,
    U_TYPE = 3'd3,
    J_TYPE = 3'd4
  } immType_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    immType_e    imm_type;
    logic        has_imm;
    logic        illegal;
  } entry_t;
endpackage

module decode_ctrl
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output immType_e    imm_type,
  output logic        has_imm,
  output logic        illegal
);

  entry_t main_q;
  entry_t skid_q;
  entry_t in_ent;
  logic   main_vld;
  logic   skid_vld;
  logic   accept;
  logic   drain;

  assign accept = in_valid & in_ready;
  assign drain  = main_vld & out_ready;

  always_comb begin
    in_ent          = '0;
    in_ent.inst     = in_inst;
    in_ent.pc       = in_pc;
    in_ent.imm_type = I_TYPE;
    in_ent.has_imm  = 1'b0;
    in_ent.illegal  = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      in_ent.illegal = 1'b1;
    end else begin
      case (in_inst[6:0])
        7'b0110111, 7'b0010111: begin
          in_ent.imm_type = U_TYPE;
          in_ent.has_imm  = 1'b1;
        end
        7'b1101111: begin
          in_ent.imm_type = J_TYPE;
          in_ent.has_imm  = 1'b1;
        end
        7'b1100011: begin
          in_ent.imm_type = B_TYPE;
          in_ent.has_imm  = 1'b1;
        end
        7'b0100011: begin
          in_ent.imm_type = S_TYPE;
          in_ent.has_imm  = 1'b1;
        end
        7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
          in_ent.has_imm = 1'b1;
        end
        7'b0110011: begin
          in_ent.has_imm = 1'b0;
        end
        default: begin
          in_ent.illegal = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      // in_ready is low here, so only the skid-to-main refill can happen
      if (drain) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!main_vld || out_ready) begin
        main_q   <= in_ent;
        main_vld <= 1'b1;
      end else begin
        skid_q   <= in_ent;
        skid_vld <= 1'b1;
      end
    end else if (drain) begin
      main_vld <= 1'b0;
    end
  end

  assign in_ready  = ~skid_vld;
  assign out_valid = main_vld;
  assign out_inst  = main_q.inst;
  assign out_pc    = main_q.pc;
  assign imm_type  = main_q.imm_type;
  assign has_imm   = main_q.has_imm;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed, table-driven bench for decode_ctrl: classification, skid buffering, flush and async reset.
module tb_decode_ctrl;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  immType_e    imm_type;
  logic        has_imm;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  decode_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .in_pc    (in_pc),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_pc   (out_pc),
    .imm_type (imm_type),
    .has_imm  (has_imm),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [2:0]  e_imm;
    logic        e_has;
    logic        e_ill;
  } vec_t;

  vec_t vecs[$];

  localparam logic [2:0] TI = 3'd0, TS = 3'd1, TB = 3'd2, TU = 3'd3, TJ = 3'd4;

  function automatic vec_t mk(input logic vld, input logic [31:0] inst, input logic [31:0] pc,
                              input logic ordy, input logic fl, input logic e_ov, input logic e_ir,
                              input logic [31:0] e_inst, input logic [31:0] e_pc, input logic [2:0] e_imm,
                              input logic e_has, input logic e_ill);
    vec_t v;
    v.vld = vld; v.inst = inst; v.pc = pc; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_inst = e_inst; v.e_pc = e_pc;
    v.e_imm = e_imm; v.e_has = e_has; v.e_ill = e_ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input vec_t v);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(v.e_ir));
    if (v.e_ov) begin
      chk({tag, " out_inst"}, out_inst, v.e_inst);
      chk({tag, " out_pc"}, out_pc, v.e_pc);
      chk({tag, " imm_type"}, 32'(imm_type), 32'(v.e_imm));
      chk({tag, " has_imm"}, 32'(has_imm), 32'(v.e_has));
      chk({tag, " illegal"}, 32'(illegal), 32'(v.e_ill));
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    in_valid  = v.vld;
    in_inst   = v.inst;
    in_pc     = v.pc;
    out_ready = v.ordy;
    flush     = v.fl;
    @(posedge clk);
    #1;
    check_out(tag, v);
  endtask

  initial begin
    // full-rate stream and classification map
    vecs.push_back(mk(1, 32'h00500093, 32'h100, 1, 0, 1, 1, 32'h00500093, 32'h100, TI, 1, 0));
    vecs.push_back(mk(1, 32'h00112023, 32'h104, 1, 0, 1, 1, 32'h00112023, 32'h104, TS, 1, 0));
    vecs.push_back(mk(1, 32'hFE000EE3, 32'h108, 1, 0, 1, 1, 32'hFE000EE3, 32'h108, TB, 1, 0));
    vecs.push_back(mk(1, 32'h000012B7, 32'h10C, 1, 0, 1, 1, 32'h000012B7, 32'h10C, TU, 1, 0));
    vecs.push_back(mk(1, 32'h008000EF, 32'h110, 1, 0, 1, 1, 32'h008000EF, 32'h110, TJ, 1, 0));
    vecs.push_back(mk(1, 32'h002081B3, 32'h114, 1, 0, 1, 1, 32'h002081B3, 32'h114, TI, 0, 0));
    vecs.push_back(mk(1, 32'h0000007F, 32'h118, 1, 0, 1, 1, 32'h0000007F, 32'h118, TI, 0, 1));
    vecs.push_back(mk(1, 32'h00000010, 32'h11C, 1, 0, 1, 1, 32'h00000010, 32'h11C, TI, 0, 1));
    vecs.push_back(mk(1, 32'h00000017, 32'h120, 1, 0, 1, 1, 32'h00000017, 32'h120, TU, 1, 0));
    vecs.push_back(mk(1, 32'h00000067, 32'h124, 1, 0, 1, 1, 32'h00000067, 32'h124, TI, 1, 0));
    vecs.push_back(mk(1, 32'h00000003, 32'h128, 1, 0, 1, 1, 32'h00000003, 32'h128, TI, 1, 0));
    vecs.push_back(mk(1, 32'h0000000F, 32'h12C, 1, 0, 1, 1, 32'h0000000F, 32'h12C, TI, 1, 0));
    vecs.push_back(mk(1, 32'h00000073, 32'h130, 1, 0, 1, 1, 32'h00000073, 32'h130, TI, 1, 0));
    vecs.push_back(mk(0, 32'h0,        32'h0,   1, 0, 0, 1, 32'h0,        32'h0,   TI, 0, 0));
    // backpressure: main, skid, third held, then drain in order
    vecs.push_back(mk(1, 32'h00000013, 32'h200, 0, 0, 1, 1, 32'h00000013, 32'h200, TI, 1, 0));
    vecs.push_back(mk(1, 32'h00002023, 32'h204, 0, 0, 1, 0, 32'h00000013, 32'h200, TI, 1, 0));
    vecs.push_back(mk(1, 32'h00000063, 32'h208, 0, 0, 1, 0, 32'h00000013, 32'h200, TI, 1, 0));
    vecs.push_back(mk(1, 32'h00000063, 32'h208, 1, 0, 1, 1, 32'h00002023, 32'h204, TS, 1, 0));
    vecs.push_back(mk(1, 32'h00000063, 32'h208, 1, 0, 1, 1, 32'h00000063, 32'h208, TB, 1, 0));
    vecs.push_back(mk(0, 32'h0,        32'h0,   0, 0, 1, 1, 32'h00000063, 32'h208, TB, 1, 0));
    vecs.push_back(mk(0, 32'h0,        32'h0,   1, 0, 0, 1, 32'h0,        32'h0,   TI, 0, 0));
    // flush with both entries full, then flush with a concurrent handshake
    vecs.push_back(mk(1, 32'h00000037, 32'h300, 0, 0, 1, 1, 32'h00000037, 32'h300, TU, 1, 0));
    vecs.push_back(mk(1, 32'h0000006F, 32'h304, 0, 0, 1, 0, 32'h00000037, 32'h300, TU, 1, 0));
    vecs.push_back(mk(1, 32'h00000033, 32'h308, 0, 1, 0, 1, 32'h0,        32'h0,   TI, 0, 0));
    vecs.push_back(mk(1, 32'h00000093, 32'h30C, 0, 0, 1, 1, 32'h00000093, 32'h30C, TI, 1, 0));
    vecs.push_back(mk(1, 32'h00000023, 32'h310, 1, 1, 0, 1, 32'h0,        32'h0,   TI, 0, 0));
    vecs.push_back(mk(0, 32'h0,        32'h0,   1, 0, 0, 1, 32'h0,        32'h0,   TI, 0, 0));
    vecs.push_back(mk(1, 32'h00000063, 32'h314, 1, 0, 1, 1, 32'h00000063, 32'h314, TB, 1, 0));
    vecs.push_back(mk(0, 32'h0,        32'h0,   1, 0, 0, 1, 32'h0,        32'h0,   TI, 0, 0));

    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_inst", out_inst, 32'd0);
    chk("reset out_pc", out_pc, 32'd0);
    chk("reset imm_type", 32'(imm_type), 32'(TI));
    chk("reset has_imm", 32'(has_imm), 32'd0);
    chk("reset illegal", 32'(illegal), 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // asynchronous reset mid-stream with both entries occupied
    step("rst_fill0", mk(1, 32'h00000013, 32'h400, 0, 0, 1, 1, 32'h00000013, 32'h400, TI, 1, 0));
    step("rst_fill1", mk(1, 32'h00000023, 32'h404, 0, 0, 1, 0, 32'h00000013, 32'h400, TI, 1, 0));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_inst", out_inst, 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step("post_rst0", mk(1, 32'h00000037, 32'h500, 1, 0, 1, 1, 32'h00000037, 32'h500, TU, 1, 0));
    step("post_rst1", mk(0, 32'h0,        32'h0,   1, 0, 0, 1, 32'h0,        32'h0,   TI, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
